contador_arb: RTL

CONTADOR_ARB -- requirements
Module: contador_arb

---
 rtl/contador_arb.sv | 125 ++++++++++++
 1 files changed

// File: rtl/contador_arb.sv
`default_nettype none
// ============================================================================
// Module      : contador_arb
// Description : Two-requester arbiter that owns one shared counter. The
//               winner's terminal count is captured at grant, the counter
//               runs 0..target inclusive, then a one-cycle done pulse is
//               returned to the owner. Round-robin between requesters by
//               default; define CONTADOR_ARB_PRIO_EN for fixed priority
//               (req0 wins every tie).
// Revision    : 1.0 - initial release
// ============================================================================
module contador_arb #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] tgt0,
   input  logic [WIDTH-1:0] tgt1,
   output logic [1:0]       gnt,
   output logic [WIDTH-1:0] cnt,
   output logic             busy,
   output logic [1:0]       done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [WIDTH-1:0] r_tgt_q;
   logic [WIDTH-1:0] r_cnt;
   logic [1:0]       r_gnt;
   logic [1:0]       r_done;
   logic             r_busy;
   logic             r_last;   // index of the requester served most recently

   logic             w_win;    // index of the requester that would be granted now
   logic             w_own_req;

   // Pick the winner among the currently asserted requests.
   always_comb begin
      w_win = 1'b0;
`ifdef CONTADOR_ARB_PRIO_EN
      w_win = ~req0;
`else
      if (req0 && req1) begin
         w_win = ~r_last;
      end else begin
         w_win = ~req0;
      end
`endif
   end

   // Request line of whichever requester currently holds the grant.
   always_comb begin
      w_own_req = r_gnt[1] ? req1 : req0;
   end

   // Arbitration / counting state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_tgt_q <= '0;
         r_cnt   <= '0;
         r_gnt   <= 2'b00;
         r_done  <= 2'b00;
         r_busy  <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 2'b00;
               if (req0 || req1) begin
                  r_tgt_q <= w_win ? tgt1 : tgt0;
                  r_gnt   <= w_win ? 2'b10 : 2'b01;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (!w_own_req) begin
                  // Owner withdrew: abandon the run silently.
                  r_gnt   <= 2'b00;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else if (r_cnt != r_tgt_q) begin
                  r_cnt <= r_cnt + c_one;
               end else begin
                  r_done  <= r_gnt;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_last  <= r_gnt[1];
               r_gnt   <= 2'b00;
               r_done  <= 2'b00;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_gnt   <= 2'b00;
               r_done  <= 2'b00;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt  = r_gnt;
   assign cnt  = r_cnt;
   assign busy = r_busy;
   assign done = r_done;

endmodule
`default_nettype wire
